// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with word RAM and end-of-test FSM
// Combinational reads, synchronous writes; a store to RESULT_ADDR or a RUN-cycle timeout ends the test.
module dmem_responder #(
  parameter int          DEPTH_WORDS  = 64,
  parameter logic [31:0] RESULT_ADDR  = 32'd100,
  parameter logic [31:0] RESULT_VALUE = 32'd25,
  parameter int          TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic        err,
  output logic [15:0] store_count,
  output logic [15:0] cycle_count
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t        state, state_next;
  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          in_range, aligned, wr_req, accept, bad, is_result;

  assign word_idx = DataAdr[AW+1:2];
  assign in_range = DataAdr < LIMIT;
  assign aligned  = DataAdr[1:0] == 2'b00;
  assign wr_req   = (state == S_RUN) && MemWrite;
  // The result address is accepted even when it lies beyond the RAM window.
  assign accept    = wr_req && aligned && (in_range || DataAdr == RESULT_ADDR);
  assign bad       = wr_req && !accept;
  assign is_result = accept && (DataAdr == RESULT_ADDR);

  assign ReadData = in_range ? ram[word_idx] : 32'd0;
  assign done     = state != S_RUN;
  assign pass     = state == S_PASS;

  always_comb begin
    state_next = state;
    if (state == S_RUN) begin
      if (is_result)
        state_next = (WriteData == RESULT_VALUE) ? S_PASS : S_FAIL;
      else if (cycle_count == TMO_LAST)
        state_next = S_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      err         <= 1'b0;
      store_count <= 16'd0;
      cycle_count <= 16'd0;
      for (int i = 0; i < DEPTH_WORDS; i++)
        ram[i] <= 32'd0;
    end else begin
      state <= state_next;
      if (accept && in_range)
        ram[word_idx] <= WriteData;
      if (accept && store_count != 16'hFFFF)
        store_count <= store_count + 16'd1;
      if (bad)
        err <= 1'b1;
      // The edge that leaves RUN is not counted as a RUN cycle.
      if (state == S_RUN && state_next == S_RUN && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule
